fwd_hazard_unit: RTL and testbench

- Parametrised forwarding and load-use hazard unit for the pipelined RISC-V core.
- Tracks in-flight register writers in an internal shadow pipeline of DEPTH stages, from EX->MEM through the last stage before the regfile.
- For each of NSRC EX-stage source operands, it selects the youngest ready producer stage to forward from.
- It raises a stall when the youngest matching producer is a load whose data is not yet available.
- Unlike the previous 2-source, 2-stage unit, it gates on write-enable, source-used and x0, and supports hold, flush and configurable load latency.

---
 rtl/fwd_hazard_pkg.sv | 12 +
 rtl/fwd_hazard_unit_match.sv | 29 ++
 rtl/fwd_hazard_unit.sv | 77 +++++++
 tb/tb_fwd_hazard_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_pkg.sv
// fwd_hazard_pkg: shared constants and shadow-pipeline entry type for fwd_hazard_unit
package fwd_hazard_pkg;
    localparam int FWD_SEL_REGFILE = 0;
    localparam int REG_X0 = 0;
    // rd is stored at a fixed maximum width so one entry type serves every NREG
    localparam int RIDX_MAX_W = 8;
    typedef struct packed {
        logic valid;
        logic [RIDX_MAX_W-1:0] rd;
        logic is_load;
    } entry_t;
endpackage

// File: rtl/fwd_hazard_unit_match.sv
// fwd_src_match: youngest-producer search for one EX source operand
module fwd_src_match
    import fwd_hazard_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int RIDX_W = 5,
    parameter int SEL_W = 2
) (
    input  entry_t [DEPTH:1]    ent_i,
    input  logic [RIDX_W-1:0]   rs_i,
    input  logic                used_i,
    output logic [SEL_W-1:0]    fwd_sel_o,
    output logic                hazard_o
);
    logic found;
    always_comb begin
        found = 1'b0;
        fwd_sel_o = SEL_W'(FWD_SEL_REGFILE);
        hazard_o = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && used_i && ent_i[k].valid && rs_i != RIDX_W'(REG_X0) && ent_i[k].rd == RIDX_MAX_W'(rs_i)) begin
                found = 1'b1;
                hazard_o = ent_i[k].is_load && k < LOAD_READY_STAGE;
                fwd_sel_o = hazard_o ? SEL_W'(FWD_SEL_REGFILE) : SEL_W'(k);
            end
        end
    end
endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use stall for the EX stage
// Optional perf counters under `define FWD_HAZARD_PERF_EN.
module fwd_hazard_unit
    import fwd_hazard_pkg::*;
#(
    parameter int NREG = 32,
    parameter int RIDX_W = $clog2(NREG),
    parameter int NSRC = 2,
    parameter int DEPTH = 2,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic                    flush,
    input  logic                    ex_valid,
    input  logic [RIDX_W-1:0]       ex_rd,
    input  logic                    ex_we,
    input  logic                    ex_is_load,
    input  logic [NSRC*RIDX_W-1:0]  ex_rs_flat,
    input  logic [NSRC-1:0]         ex_rs_used,
    output logic [NSRC*SEL_W-1:0]   fwd_sel_flat,
    output logic                    stall
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]             perf_stall_cnt,
    output logic [31:0]             perf_fwd_cnt
`endif
);
    entry_t [DEPTH:1] ent_q, ent_d;
    logic [NSRC-1:0] hazard;
    genvar i;
    generate
        for (i = 0; i < NSRC; i++) begin : g_src
            fwd_src_match #(
                .DEPTH(DEPTH),
                .LOAD_READY_STAGE(LOAD_READY_STAGE),
                .RIDX_W(RIDX_W),
                .SEL_W(SEL_W)
            ) u_match (
                .ent_i(ent_q),
                .rs_i(ex_rs_flat[i*RIDX_W +: RIDX_W]),
                .used_i(ex_rs_used[i]),
                .fwd_sel_o(fwd_sel_flat[i*SEL_W +: SEL_W]),
                .hazard_o(hazard[i])
            );
        end
    endgenerate
    assign stall = ex_valid & ~flush & (|hazard);
    // a stalled consumer leaves a bubble in stage 1 while older entries age
    always_comb begin
        ent_d = ent_q;
        for (int k = DEPTH; k >= 2; k--) ent_d[k] = ent_q[k-1];
        ent_d[1].valid = ex_valid & ex_we & (ex_rd != RIDX_W'(REG_X0)) & ~flush & ~stall;
        ent_d[1].rd = RIDX_MAX_W'(ex_rd);
        ent_d[1].is_load = ex_is_load;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ent_q <= '0;
        else if (!hold) ent_q <= ent_d;
    end
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, fwd_cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            fwd_cnt_q <= '0;
        end else if (!hold) begin
            if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
            else if (|fwd_sel_flat) fwd_cnt_q <= fwd_cnt_q + 32'd1;
        end
    end
    assign perf_stall_cnt = stall_cnt_q;
    assign perf_fwd_cnt = fwd_cnt_q;
`endif
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios plus randomized run against a producer-history model
module tb_fwd_hazard_unit;
    localparam int NREG = 32;
    localparam int RIDX_W = 5;
    localparam int NSRC = 2;
    localparam int DEPTH = 3;
    localparam int LRS = 2;
    localparam int SEL_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    logic flush = 1'b0;
    logic ex_valid = 1'b0;
    logic ex_we = 1'b0;
    logic ex_is_load = 1'b0;
    logic [RIDX_W-1:0] ex_rd = '0;
    logic [NSRC*RIDX_W-1:0] ex_rs_flat = '0;
    logic [NSRC-1:0] ex_rs_used = '0;
    logic [NSRC*SEL_W-1:0] fwd_sel_flat;
    logic stall;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt, perf_fwd_cnt;
`endif

    int checks = 0;
    int failures = 0;

    typedef struct {
        int v, rd, we, ld, r0, r1, used, h, f, e0, e1, es;
    } step_t;

    typedef struct {
        bit v;
        int rd;
        bit ld;
    } prod_t;

    prod_t hist[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .NREG(NREG), .RIDX_W(RIDX_W), .NSRC(NSRC),
        .DEPTH(DEPTH), .LOAD_READY_STAGE(LRS), .SEL_W(SEL_W)
    ) dut (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load),
        .ex_rs_flat(ex_rs_flat), .ex_rs_used(ex_rs_used),
        .fwd_sel_flat(fwd_sel_flat), .stall(stall)
`ifdef FWD_HAZARD_PERF_EN
        , .perf_stall_cnt(perf_stall_cnt), .perf_fwd_cnt(perf_fwd_cnt)
`endif
    );

    function automatic step_t mk(input int v, input int rd, input int we, input int ld,
                                 input int r0, input int r1, input int used, input int h,
                                 input int f, input int e0, input int e1, input int es);
        step_t s;
        s.v = v; s.rd = rd; s.we = we; s.ld = ld;
        s.r0 = r0; s.r1 = r1; s.used = used; s.h = h;
        s.f = f; s.e0 = e0; s.e1 = e1; s.es = es;
        return s;
    endfunction

    task automatic apply(input step_t s);
        ex_valid = (s.v != 0);
        ex_rd = RIDX_W'(s.rd);
        ex_we = (s.we != 0);
        ex_is_load = (s.ld != 0);
        ex_rs_flat = {RIDX_W'(s.r1), RIDX_W'(s.r0)};
        ex_rs_used = NSRC'(s.used);
        hold = (s.h != 0);
        flush = (s.f != 0);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        apply(mk(1, 0, 0, 0, 5, 6, 3, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if (fwd_sel_flat !== '0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: sel=%h stall=%b required sel=0 stall=0", fwd_sel_flat, stall);
        end
        tick();
        rst = 1'b0;
        apply(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        apply(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        apply(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0)); tick();
        apply(mk(1, 8, 1, 0, 7, 5, 3, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if (fwd_sel_flat !== {2'd3, 2'd0} || stall !== 1'b1) begin
            failures++;
            $display("FAIL reset_prefill: sel=%h stall=%b required sel=c stall=1", fwd_sel_flat, stall);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (fwd_sel_flat !== '0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: sel=%h stall=%b required sel=0 stall=0", fwd_sel_flat, stall);
        end
        tick();
        rst = 1'b0;
        apply(mk(1, 0, 0, 0, 5, 6, 3, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if (fwd_sel_flat !== '0 || stall !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: sel=%h stall=%b required sel=0 stall=0", fwd_sel_flat, stall);
        end
        tick();
    endtask

    task automatic test_alu;
        step_t s[$];
        do_reset();
        s.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 9, 1, 0, 5, 0, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 5, 0, 1, 0, 0, 2, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 5, 5, 3, 0, 0, 3, 3, 0));
        s.push_back(mk(1, 0, 0, 0, 5, 9, 3, 0, 0, 0, 3, 0));
        foreach (s[j]) begin
            apply(s[j]);
            #1;
            checks++;
            if (fwd_sel_flat !== {SEL_W'(s[j].e1), SEL_W'(s[j].e0)} || stall !== (s[j].es != 0)) begin
                failures++;
                $display("FAIL alu step %0d: sel=%h stall=%b required sel=%h stall=%0d",
                         j, fwd_sel_flat, stall, {SEL_W'(s[j].e1), SEL_W'(s[j].e0)}, s[j].es);
            end
            tick();
        end
    endtask

    task automatic test_load_use;
        step_t s[$];
        do_reset();
        s.push_back(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 8, 1, 0, 8, 7, 3, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 8, 1, 0, 8, 7, 3, 0, 0, 0, 2, 0));
        s.push_back(mk(1, 0, 0, 0, 8, 7, 3, 0, 0, 1, 3, 0));
        foreach (s[j]) begin
            apply(s[j]);
            #1;
            checks++;
            if (fwd_sel_flat !== {SEL_W'(s[j].e1), SEL_W'(s[j].e0)} || stall !== (s[j].es != 0)) begin
                failures++;
                $display("FAIL load_use step %0d: sel=%h stall=%b required sel=%h stall=%0d",
                         j, fwd_sel_flat, stall, {SEL_W'(s[j].e1), SEL_W'(s[j].e0)}, s[j].es);
            end
            tick();
        end
    endtask

    task automatic test_youngest;
        step_t s[$];
        do_reset();
        s.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 3, 3, 3, 0, 0, 1, 1, 0));
        s.push_back(mk(1, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 3, 3, 3, 0, 0, 0, 0, 1));
        s.push_back(mk(1, 0, 0, 0, 3, 3, 3, 0, 0, 2, 2, 0));
        foreach (s[j]) begin
            apply(s[j]);
            #1;
            checks++;
            if (fwd_sel_flat !== {SEL_W'(s[j].e1), SEL_W'(s[j].e0)} || stall !== (s[j].es != 0)) begin
                failures++;
                $display("FAIL youngest step %0d: sel=%h stall=%b required sel=%h stall=%0d",
                         j, fwd_sel_flat, stall, {SEL_W'(s[j].e1), SEL_W'(s[j].e0)}, s[j].es);
            end
            tick();
        end
    endtask

    task automatic test_gating;
        step_t s[$];
        do_reset();
        s.push_back(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 0, 1, 1, 0, 0, 3, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 4, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 6, 1, 1, 4, 0, 1, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 6, 6, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(1, 10, 1, 0, 7, 6, 3, 0, 1, 0, 3, 0));
        s.push_back(mk(0, 0, 0, 0, 7, 10, 3, 0, 0, 2, 0, 0));
        s.push_back(mk(1, 11, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        s.push_back(mk(0, 0, 0, 0, 11, 0, 1, 0, 0, 0, 0, 0));
        foreach (s[j]) begin
            apply(s[j]);
            #1;
            checks++;
            if (fwd_sel_flat !== {SEL_W'(s[j].e1), SEL_W'(s[j].e0)} || stall !== (s[j].es != 0)) begin
                failures++;
                $display("FAIL gating step %0d: sel=%h stall=%b required sel=%h stall=%0d",
                         j, fwd_sel_flat, stall, {SEL_W'(s[j].e1), SEL_W'(s[j].e0)}, s[j].es);
            end
            tick();
        end
    endtask

    task automatic test_hold;
        do_reset();
        apply(mk(1, 7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        tick();
        for (int c = 0; c < 3; c++) begin
            apply(mk(1, 8, 1, 0, 8, 7, 3, 1, 0, 0, 0, 0));
            #1;
            checks++;
            if (fwd_sel_flat !== '0 || stall !== 1'b1) begin
                failures++;
                $display("FAIL hold cycle %0d: sel=%h stall=%b required sel=0 stall=1", c, fwd_sel_flat, stall);
            end
            tick();
        end
`ifdef FWD_HAZARD_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_stall_hold: cnt=%0d required 0", perf_stall_cnt);
        end
`endif
        apply(mk(1, 8, 1, 0, 8, 7, 3, 0, 0, 0, 0, 0));
        #1;
        checks++;
        if (fwd_sel_flat !== '0 || stall !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: sel=%h stall=%b required sel=0 stall=1", fwd_sel_flat, stall);
        end
        tick();
        #1;
        checks++;
        if (fwd_sel_flat !== {2'd2, 2'd0} || stall !== 1'b0) begin
            failures++;
            $display("FAIL hold_complete: sel=%h stall=%b required sel=8 stall=0", fwd_sel_flat, stall);
        end
        tick();
`ifdef FWD_HAZARD_PERF_EN
        checks++;
        if (perf_stall_cnt !== 32'd1 || perf_fwd_cnt !== 32'd1) begin
            failures++;
            $display("FAIL perf_after: stall_cnt=%0d fwd_cnt=%0d required 1 and 1", perf_stall_cnt, perf_fwd_cnt);
        end
`endif
    endtask

    task automatic test_random;
        step_t s;
        prod_t p;
        int rs[NSRC];
        int sel[NSRC];
        bit haz, es;
        do_reset();
        hist.delete();
        for (int c = 0; c < 600; c++) begin
            s = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7), $urandom_range(0, 1),
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 3), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                   0, 0, 0);
            rs[0] = s.r0;
            rs[1] = s.r1;
            haz = 1'b0;
            for (int i = 0; i < NSRC; i++) begin
                sel[i] = 0;
                if (s.used[i] && rs[i] != 0) begin
                    for (int k = 0; k < hist.size(); k++) begin
                        if (hist[k].v && hist[k].rd == rs[i]) begin
                            if (hist[k].ld && k + 1 < LRS) haz = 1'b1;
                            else sel[i] = k + 1;
                            break;
                        end
                    end
                end
            end
            es = (s.v != 0) && (s.f == 0) && haz;
            apply(s);
            #1;
            checks++;
            if (fwd_sel_flat !== {SEL_W'(sel[1]), SEL_W'(sel[0])} || stall !== es) begin
                failures++;
                $display("FAIL random cyc %0d: sel=%h stall=%b required sel=%h stall=%b",
                         c, fwd_sel_flat, stall, {SEL_W'(sel[1]), SEL_W'(sel[0])}, es);
            end
            tick();
            if (s.h == 0) begin
                p.v = s.v != 0 && s.we != 0 && s.rd != 0 && s.f == 0 && !es;
                p.rd = s.rd;
                p.ld = s.ld != 0;
                hist.push_front(p);
                if (hist.size() > DEPTH) void'(hist.pop_back());
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_use();
        test_youngest();
        test_gating();
        test_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
